conv_layer_sequencer: RTL and testbench
=======================================

// Module: conv_layer_sequencer
// PURPOSE
//  Layer-level controller that sequences address_generator across a multi-layer CNN pass.
//  Holds a small table of per-layer conv configs written by the host and launches layers in order.
//  For each layer: derives OFM_W, validates the config, drives the address_generator config and
//  addr_in base, raises ready, waits for done_compute, then advances. Sits between host/top FSM and addr gen.
// PARAMETERS
//  MAX_LAYERS  8   depth of layer config table (power of 2); LIDX_W = $clog2(MAX_LAYERS)
//  DATA_WIDTH  32  width of base address / addr_in
//  TOTAL_PE    16  PE count; every layer's OFM_C must be a nonzero multiple of it
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  cfg_we       in   1        write table entry cfg_idx (ignored while busy)
//  cfg_idx      in   LIDX_W   entry index
//  cfg_kernel_w in   4        KERNEL_W for entry
//  cfg_ifm_w    in   8        IFM_W for entry
//  cfg_ifm_c    in   8        IFM_C for entry
//  cfg_ofm_c    in   8        OFM_C for entry
//  cfg_stride   in   2        stride for entry (legal: 1, 2)
//  cfg_base     in   DATA_WIDTH  base address for entry
//  start        in   1        1-cycle pulse; run layers 0..num_layers-1 (ignored while busy)
//  num_layers   in   LIDX_W+1 layer count, sampled with start; values >MAX_LAYERS clamp to MAX_LAYERS
//  abort        in   1        stop run, return to IDLE
//  done_compute in   1        level from address_generator: current layer finished
//  KERNEL_W, IFM_W, IFM_C, OFM_C, OFM_W, stride  out  4/8/8/8/8/2  registered config to addr gen
//  addr_in      out  DATA_WIDTH   registered layer base to addr gen
//  ready        out  1        start/enable to address_generator
//  busy         out  1        high from LOAD through DRAIN of last layer
//  layer_idx    out  LIDX_W   index of layer in flight
//  run_done     out  1        1-cycle pulse at end of run (not on abort)
//  cfg_err      out  1        sticky: some layer skipped as illegal; cleared by next accepted start
// BEHAVIOUR
//  Reset: all outputs 0, table contents 0, state IDLE.
//  FSM: IDLE -> LOAD -> CHECK -> SETUP -> RUN -> DRAIN -> NEXT -> (LOAD | FINISH) -> IDLE.
//   IDLE: start accepted -> latch num_layers, layer_idx=0, clear cfg_err; num_layers==0 -> FINISH.
//   LOAD: register table[layer_idx]. CHECK: compute OFM_W = ((IFM_W-KERNEL_W)>>(stride==2))+1 in 9 bits,
//     truncate to 8; illegal if stride∉{1,2}, KERNEL_W==0, KERNEL_W>IFM_W, OFM_C==0 or OFM_C%TOTAL_PE!=0.
//     Illegal -> set cfg_err, go NEXT (ready never raised for that layer).
//   SETUP: drive config outputs + addr_in (held stable until next SETUP). RUN: ready=1 until
//     done_compute sampled 1. DRAIN: ready=0, wait done_compute==0 (covers gens that hold done high).
//   NEXT: layer_idx+1; if ==num_layers -> FINISH else LOAD. FINISH: run_done=1 one cycle, busy=0.
//  Latency: start sampled at edge T0 -> ready high after edge T0+3; done_compute seen at edge Tn ->
//   ready low after Tn; next layer ready after DRAIN exit + 4 edges.
//  done_compute high outside RUN/DRAIN ignored. done_compute already high on RUN entry: 1-cycle RUN.
//  abort (any state) -> next edge: ready=0, busy=0, state IDLE, no run_done; config outputs keep value.
//  abort and start same cycle: abort wins. cfg_we and start same cycle in IDLE: write lands, run uses it
//   (LOAD reads a cycle later). cfg_we while busy: dropped silently.
//  Async reset mid-run: immediate return to reset values; table cleared.
// STRUCTURE
//  Package conv_seq_pkg: state enum seq_state_e, struct layer_cfg_t {kernel_w, ifm_w, ifm_c, ofm_c,
//   stride, base}, localparams for stride codes.
//  Sub-module layer_cfg_table: MAX_LAYERS x layer_cfg_t flops, 1 write port, registered read port.
//  Top holds FSM, OFM_W/legality logic, output registers.
// TESTING
//  1 layer K=3,IFM_W=10,IFM_C=16,OFM_C=16,s=2,base=0x100; start -> OFM_W=4, addr_in=0x100, ready at T0+3,
//    model done_compute after 20 cycles -> ready drops, run_done pulse once, busy 0.
//  3 layers (s=1 K=3 W=10 -> OFM_W=8; s=2 K=1 W=8 -> OFM_W=4; s=1 K=5 W=5 -> OFM_W=1) -> exactly 3
//    ready windows, configs/bases in order, layer_idx 0,1,2.
//  Layer 1 of 3 with OFM_C=24 (TOTAL_PE=16) or stride=3 -> skipped, no ready for it, cfg_err=1, run_done.
//  done_compute held high 5 cycles after completion -> sequencer stays in DRAIN, next ready only after low.
//  abort during RUN of layer 1 -> ready 0 next edge, busy 0, no run_done; new start re-runs from layer 0.
//  num_layers=0 start -> run_done 1 cycle later-path, ready never high; cfg_we while busy leaves table unchanged.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared types and helpers for the conv layer sequencer
// Contents: seq_state_e FSM states, layer_cfg_t table entry, stride codes,
//           calc_ofm_w() output-width helper.
package conv_seq_pkg;

  localparam int BASE_W = 32;

  localparam logic [1:0] STRIDE_1 = 2'd1;
  localparam logic [1:0] STRIDE_2 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_SETUP,
    S_RUN,
    S_DRAIN,
    S_NEXT,
    S_FINISH
  } seq_state_e;

  typedef struct packed {
    logic [3:0]        kernel_w;
    logic [7:0]        ifm_w;
    logic [7:0]        ifm_c;
    logic [7:0]        ofm_c;
    logic [1:0]        stride;
    logic [BASE_W-1:0] base;
  } layer_cfg_t;

  // Computed in 9 bits so an illegal KERNEL_W > IFM_W wraps harmlessly;
  // only legal layers ever reach the output register.
  function automatic logic [7:0] calc_ofm_w(input layer_cfg_t c);
    logic [8:0] diff;
    diff = {1'b0, c.ifm_w} - {5'd0, c.kernel_w};
    if (c.stride == STRIDE_2) diff = diff >> 1;
    return 8'(diff + 9'd1);
  endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// rtl/conv_layer_sequencer_if.sv - sequencer <-> address_generator link
// master (sequencer): drives KERNEL_W, IFM_W, IFM_C, OFM_C, OFM_W, stride,
//                     addr_in, ready; samples done_compute.
// slave  (addr gen) : the reverse directions.
interface conv_layer_sequencer_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [3:0]            KERNEL_W;
  logic [7:0]            IFM_W;
  logic [7:0]            IFM_C;
  logic [7:0]            OFM_C;
  logic [7:0]            OFM_W;
  logic [1:0]            stride;
  logic [DATA_WIDTH-1:0] addr_in;
  logic                  ready;
  logic                  done_compute;

  modport master (
    output KERNEL_W, IFM_W, IFM_C, OFM_C, OFM_W, stride, addr_in, ready,
    input  done_compute
  );

  modport slave (
    input  KERNEL_W, IFM_W, IFM_C, OFM_C, OFM_W, stride, addr_in, ready,
    output done_compute
  );
endinterface

// File: rtl/layer_cfg_table.sv
// rtl/layer_cfg_table.sv - per-layer config storage, one write port, registered read
// Ports: clk, rst_n (async, clears all entries); we/wr_idx/wr_data write;
//        rd_idx -> rd_data one cycle later.
module layer_cfg_table
  import conv_seq_pkg::*;
#(
  parameter  int MAX_LAYERS = 8,
  localparam int LIDX_W     = $clog2(MAX_LAYERS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [LIDX_W-1:0] wr_idx,
  input  layer_cfg_t        wr_data,
  input  logic [LIDX_W-1:0] rd_idx,
  output layer_cfg_t        rd_data
);

  layer_cfg_t mem [MAX_LAYERS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LAYERS; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (we) mem[wr_idx] <= wr_data;
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// rtl/conv_layer_sequencer.sv - launches address_generator layer by layer from a config table
// Ports: clk, rst_n (async active-low)
//        host table write : cfg_we, cfg_idx, cfg_kernel_w/ifm_w/ifm_c/ofm_c/stride/base
//        run control      : start, num_layers, abort
//        ag (master)      : layer config + addr_in + ready out, done_compute in
//        status           : busy, layer_idx, run_done, cfg_err
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter  int MAX_LAYERS = 8,
  parameter  int DATA_WIDTH = 32,
  parameter  int TOTAL_PE   = 16,
  localparam int LIDX_W     = $clog2(MAX_LAYERS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [LIDX_W-1:0]      cfg_idx,
  input  logic [3:0]             cfg_kernel_w,
  input  logic [7:0]             cfg_ifm_w,
  input  logic [7:0]             cfg_ifm_c,
  input  logic [7:0]             cfg_ofm_c,
  input  logic [1:0]             cfg_stride,
  input  logic [DATA_WIDTH-1:0]  cfg_base,
  input  logic                   start,
  input  logic [LIDX_W:0]        num_layers,
  input  logic                   abort,
  conv_layer_sequencer_if.master ag,
  output logic                   busy,
  output logic [LIDX_W-1:0]      layer_idx,
  output logic                   run_done,
  output logic                   cfg_err
);

  seq_state_e       state, state_nx;
  layer_cfg_t       wr_cfg, cur;
  logic [LIDX_W:0]  num_lat, num_clamped, idx_inc;
  logic             start_ok, illegal;

  assign wr_cfg = {cfg_kernel_w, cfg_ifm_w, cfg_ifm_c, cfg_ofm_c, cfg_stride,
                   BASE_W'(cfg_base)};

  // The table only changes while idle, so cur stays stable from LOAD to SETUP.
  layer_cfg_table #(.MAX_LAYERS(MAX_LAYERS)) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we && !busy),
    .wr_idx  (cfg_idx),
    .wr_data (wr_cfg),
    .rd_idx  (layer_idx),
    .rd_data (cur)
  );

  assign start_ok    = start && !abort && (state == S_IDLE);
  assign num_clamped = (num_layers > (LIDX_W+1)'(MAX_LAYERS)) ? (LIDX_W+1)'(MAX_LAYERS)
                                                            : num_layers;
  assign idx_inc     = {1'b0, layer_idx} + (LIDX_W+1)'(1);

  always_comb begin
    illegal = ((cur.stride != STRIDE_1) && (cur.stride != STRIDE_2)) ||
              (cur.kernel_w == 4'd0) ||
              ({4'd0, cur.kernel_w} > cur.ifm_w) ||
              (cur.ofm_c == 8'd0) ||
              ((32'(cur.ofm_c) % TOTAL_PE) != 0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start_ok) state_nx = (num_clamped == '0) ? S_FINISH : S_LOAD;
      S_LOAD:   state_nx = S_CHECK;
      S_CHECK:  state_nx = illegal ? S_NEXT : S_SETUP;
      S_SETUP:  state_nx = S_RUN;
      S_RUN:    if (ag.done_compute) state_nx = S_DRAIN;
      // Some generators hold done high; wait for it to clear before moving on.
      S_DRAIN:  if (!ag.done_compute) state_nx = S_NEXT;
      S_NEXT:   state_nx = (idx_inc == num_lat) ? S_FINISH : S_LOAD;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  assign ag.ready = (state == S_RUN);
  assign busy     = (state != S_IDLE) && (state != S_FINISH);
  assign run_done = (state == S_FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_lat     <= '0;
      layer_idx   <= '0;
      cfg_err     <= 1'b0;
      ag.KERNEL_W <= '0;
      ag.IFM_W    <= '0;
      ag.IFM_C    <= '0;
      ag.OFM_C    <= '0;
      ag.OFM_W    <= '0;
      ag.stride   <= '0;
      ag.addr_in  <= '0;
    end else begin
      if (start_ok) begin
        num_lat   <= num_clamped;
        layer_idx <= '0;
        cfg_err   <= 1'b0;
      end
      if (!abort) begin
        if ((state == S_CHECK) && illegal) cfg_err <= 1'b1;
        // Index stays on the last layer at FINISH rather than wrapping.
        if ((state == S_NEXT) && (idx_inc != num_lat)) layer_idx <= idx_inc[LIDX_W-1:0];
        if (state == S_SETUP) begin
          ag.KERNEL_W <= cur.kernel_w;
          ag.IFM_W    <= cur.ifm_w;
          ag.IFM_C    <= cur.ifm_c;
          ag.OFM_C    <= cur.ofm_c;
          ag.OFM_W    <= calc_ofm_w(cur);
          ag.stride   <= cur.stride;
          ag.addr_in  <= DATA_WIDTH'(cur.base);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb/tb_conv_layer_sequencer.sv - self-checking bench for conv_layer_sequencer
module tb_conv_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [3:0]  cfg_kernel_w = '0;
  logic [7:0]  cfg_ifm_w = '0, cfg_ifm_c = '0, cfg_ofm_c = '0;
  logic [1:0]  cfg_stride = '0;
  logic [31:0] cfg_base = '0;
  logic        start = 1'b0;
  logic [3:0]  num_layers = '0;
  logic        abort = 1'b0;
  logic        busy, run_done, cfg_err;
  logic [2:0]  layer_idx;

  conv_layer_sequencer_if #(.DATA_WIDTH(32)) ag ();

  conv_layer_sequencer #(.MAX_LAYERS(8), .DATA_WIDTH(32), .TOTAL_PE(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_kernel_w(cfg_kernel_w), .cfg_ifm_w(cfg_ifm_w), .cfg_ifm_c(cfg_ifm_c),
    .cfg_ofm_c(cfg_ofm_c), .cfg_stride(cfg_stride), .cfg_base(cfg_base),
    .start(start), .num_layers(num_layers), .abort(abort), .ag(ag),
    .busy(busy), .layer_idx(layer_idx), .run_done(run_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx, k, w, c, oc, ofm, s;
    logic [31:0] base;
  } win_t;

  win_t got_q[$], exp_q[$];
  int   len_q[$];
  int   m_k[8], m_w[8], m_c[8], m_oc[8], m_s[8];
  logic [31:0] m_base[8];
  int   errors = 0, checks = 0;
  int   t0, first_ready, first_done, done_pulses;
  logic ab_ready, ab_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic bit legal(input int i);
    return (m_s[i] == 1 || m_s[i] == 2) && m_k[i] != 0 && m_k[i] <= m_w[i] &&
           m_oc[i] != 0 && (m_oc[i] % 16) == 0;
  endfunction

  task automatic write_cfg(input int i, input int k, input int w, input int c,
                           input int oc, input int s, input logic [31:0] base);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'(i); cfg_kernel_w = 4'(k); cfg_ifm_w = 8'(w);
    cfg_ifm_c = 8'(c); cfg_ofm_c = 8'(oc); cfg_stride = 2'(s); cfg_base = base;
    m_k[i] = k; m_w[i] = w; m_c[i] = c; m_oc[i] = oc; m_s[i] = s; m_base[i] = base;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1; num_layers = 4'(n);
  endtask

  // Plays the address generator: counts ready windows, raises done after
  // `work` ready cycles, holds it `hold` cycles after ready falls.
  task automatic serve(input int work, input int hold, input int abort_win,
                       input bit wr_busy, input int budget);
    int wcnt, hcnt, nwin, post, prev_idx, drop_cyc;
    bit in_win, ending, fin, ab;
    got_q.delete(); len_q.delete();
    done_pulses = 0; first_ready = -1; first_done = -1; ab_ready = 1'b1; ab_busy = 1'b1;
    wcnt = 0; hcnt = 0; nwin = 0; post = 0; prev_idx = -10; drop_cyc = 0;
    in_win = 0; ending = 0; fin = 0; ab = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 0) begin start = 1'b0; cfg_we = 1'b0; t0 = cyc; end
      if (wr_busy && c == 1) begin
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_kernel_w = 4'd7; cfg_ifm_w = 8'd9;
        cfg_ofm_c = 8'd48; cfg_stride = 2'd1; cfg_base = 32'hDEAD0000;
      end
      if (c == 2) cfg_we = 1'b0;
      if (ab) begin
        if (post == 0) begin ab_ready = ag.ready; ab_busy = busy; end
        abort = 1'b0;
      end
      if (run_done) begin
        done_pulses++;
        if (first_done < 0) first_done = cyc;
        fin = 1;
      end
      if (fin || ab) begin post++; if (post > 3) break; end
      if (ending) begin
        if (hcnt >= hold) begin ag.done_compute = 1'b0; ending = 0; drop_cyc = cyc; end
        else hcnt++;
      end
      if (ag.ready && !in_win) begin
        win_t r;
        r.idx = int'(layer_idx); r.k = int'(ag.KERNEL_W); r.w = int'(ag.IFM_W);
        r.c = int'(ag.IFM_C); r.oc = int'(ag.OFM_C); r.ofm = int'(ag.OFM_W);
        r.s = int'(ag.stride); r.base = ag.addr_in;
        got_q.push_back(r);
        if (first_ready < 0) first_ready = cyc;
        if (r.idx == prev_idx + 1) check("drain_to_ready_gap", cyc - drop_cyc, 5);
        prev_idx = r.idx; in_win = 1; wcnt = 0;
      end
      if (in_win && ag.ready) begin
        wcnt++;
        if (wcnt >= work) ag.done_compute = 1'b1;
        if (nwin == abort_win && wcnt == 3 && !ab) begin abort = 1'b1; ab = 1; end
      end else if (in_win) begin
        in_win = 0; len_q.push_back(wcnt); nwin++;
        if (hold == 0) begin ag.done_compute = 1'b0; drop_cyc = cyc; end
        else begin ending = 1; hcnt = 1; end
      end
    end
    if (!(fin || ab)) check("serve_timeout", 0, 1);
    ag.done_compute = 1'b0;
    abort = 1'b0;
  endtask

  task automatic compare_run(input int n);
    int nc;
    bit any_bad;
    nc = (n > 8) ? 8 : n;
    any_bad = 0;
    exp_q.delete();
    for (int i = 0; i < nc; i++) begin
      if (legal(i)) begin
        win_t e;
        e.idx = i; e.k = m_k[i]; e.w = m_w[i]; e.c = m_c[i]; e.oc = m_oc[i];
        e.s = m_s[i]; e.base = m_base[i];
        e.ofm = ((m_w[i] - m_k[i]) / m_s[i] + 1) % 256;
        exp_q.push_back(e);
      end else any_bad = 1;
    end
    check("n_windows", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check("win_layer_idx", got_q[i].idx, exp_q[i].idx);
      check("win_kernel_w", got_q[i].k, exp_q[i].k);
      check("win_ifm_w", got_q[i].w, exp_q[i].w);
      check("win_ifm_c", got_q[i].c, exp_q[i].c);
      check("win_ofm_c", got_q[i].oc, exp_q[i].oc);
      check("win_ofm_w", got_q[i].ofm, exp_q[i].ofm);
      check("win_stride", got_q[i].s, exp_q[i].s);
      check("win_addr_in", got_q[i].base, exp_q[i].base);
    end
    check("run_done_pulses", done_pulses, 1);
    check("busy_after_run", busy, 0);
    check("cfg_err", cfg_err, any_bad);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    ag.done_compute = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_k[i] = 0; m_w[i] = 0; m_c[i] = 0; m_oc[i] = 0; m_s[i] = 0; m_base[i] = '0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", ag.ready, 0);
    check("rst_busy", busy, 0);
    check("rst_run_done", run_done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_layer_idx", layer_idx, 0);
    check("rst_addr_in", ag.addr_in, 0);
    check("rst_ofm_w", ag.OFM_W, 0);
    check("rst_kernel_w", ag.KERNEL_W, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    // Cleared table: entry 0 is all zero, hence illegal
    do_start(1); serve(4, 0, -1, 0, 200); compare_run(1);

    // Single layer, 20-cycle compute
    write_cfg(0, 3, 10, 16, 16, 2, 32'h100);
    do_start(1); serve(20, 0, -1, 0, 500); compare_run(1);
    check("t1_ready_latency", first_ready - t0, 3);
    check("t1_ready_len", (len_q.size() > 0) ? len_q[0] : -1, 20);
    check("t1_ofm_w", (got_q.size() > 0) ? got_q[0].ofm : -1, 4);
    check("t1_addr_in", (got_q.size() > 0) ? got_q[0].base : 0, 32'h100);

    // Three layers in order
    write_cfg(0, 3, 10, $urandom_range(0, 255), 16, 1, $urandom);
    write_cfg(1, 1, 8, $urandom_range(0, 255), 32, 2, $urandom);
    write_cfg(2, 5, 5, $urandom_range(0, 255), 16, 1, $urandom);
    do_start(3); serve(5, 0, -1, 0, 1000); compare_run(3);

    // done_compute held high after completion
    do_start(3); serve(3, 5, -1, 0, 1000); compare_run(3);

    // done already high before RUN: one-cycle RUN window
    ag.done_compute = 1'b1;
    do_start(1); serve(20, 0, -1, 0, 500); compare_run(1);
    check("preset_done_len", (len_q.size() > 0) ? len_q[0] : -1, 1);

    // Abort during layer 1, then re-run from layer 0
    do_start(3); serve(10, 0, 1, 0, 1000);
    check("abort_ready", ab_ready, 0);
    check("abort_busy", ab_busy, 0);
    check("abort_no_run_done", done_pulses, 0);
    check("abort_windows", got_q.size(), 2);
    do_start(3); serve(4, 0, -1, 0, 1000); compare_run(3);

    // Illegal middle layer: OFM_C not a multiple of TOTAL_PE, then stride 3
    write_cfg(1, 1, 8, 5, 24, 2, 32'h2000);
    do_start(3); serve(3, 0, -1, 0, 1000); compare_run(3);
    write_cfg(1, 1, 8, 5, 32, 3, 32'h2000);
    do_start(3); serve(3, 0, -1, 0, 1000); compare_run(3);

    // Zero-layer run
    do_start(0); serve(1, 0, -1, 0, 50); compare_run(0);
    check("zero_run_done_latency", first_done - t0, 0);

    // Write while busy is dropped
    do_start(1); serve(3, 0, -1, 1, 300); compare_run(1);
    do_start(1); serve(3, 0, -1, 0, 300); compare_run(1);

    // Write and start in the same cycle: run sees the new entry
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_kernel_w = 4'd5; cfg_ifm_w = 8'd20; cfg_ifm_c = 8'd3;
    cfg_ofm_c = 8'd32; cfg_stride = 2'd1; cfg_base = 32'h4000;
    m_k[0] = 5; m_w[0] = 20; m_c[0] = 3; m_oc[0] = 32; m_s[0] = 1; m_base[0] = 32'h4000;
    start = 1'b1; num_layers = 4'd1;
    serve(2, 0, -1, 0, 300); compare_run(1);

    // Abort and start together: abort wins
    @(negedge clk); start = 1'b1; abort = 1'b1; num_layers = 4'd1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 0);
    seen = 0;
    repeat (6) begin @(negedge clk); if (ag.ready || run_done) seen = 1; end
    check("abort_start_quiet", seen, 0);

    // Random configurations and layer counts (including clamp above 8)
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) begin
        int sel, s;
        sel = $urandom_range(0, 7);
        s = (sel == 0) ? 0 : (sel == 1) ? 3 : (sel % 2) + 1;
        write_cfg(i, $urandom_range(0, 6), $urandom_range(0, 40), $urandom_range(0, 255),
                  8 * $urandom_range(0, 7), s, $urandom);
      end
      n = $urandom_range(1, 15);
      do_start(n); serve($urandom_range(1, 4), $urandom_range(0, 2), -1, 0, 3000);
      compare_run(n);
    end

    // Async reset mid-run clears outputs and table
    write_cfg(0, 3, 10, 16, 16, 2, 32'h100);
    do_start(1);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); start = 1'b0;
      if (ag.ready) seen = 1;
    end
    check("arst_reached_run", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", ag.ready, 0);
    check("arst_busy", busy, 0);
    check("arst_addr_in", ag.addr_in, 0);
    check("arst_ofm_w", ag.OFM_W, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m_k[i] = 0; m_w[i] = 0; m_c[i] = 0; m_oc[i] = 0; m_s[i] = 0; m_base[i] = '0;
    end
    do_start(2); serve(2, 0, -1, 0, 200); compare_run(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
